clk_div_monitor: RTL and testbench

Checker that sits on the receiving end of the clock-divider output (e.g. the divide-by-28 `clk_div_28` signal). It samples the divided signal in the `clk_in` domain, measures every high and low phase in `clk_in` cycles, and compares each phase against the expected half-period within a tolerance. It reports lock, per-phase errors, the last measured phase lengths and a saturating error count for on-board and simulation diagnostics.

---
 rtl/clk_mon_pkg.sv | 16 +
 rtl/clk_div_monitor_phase_check.sv | 27 ++
 rtl/clk_div_monitor.sv | 170 +++++++++++++++++
 tb/tb_clk_div_monitor.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/clk_mon_pkg.sv
// Shared definitions for the divided-clock monitor.
// Holds the measurement FSM state encoding, the default divider
// constants (divide-by-28, 50% duty) and the error counter width.
package clk_mon_pkg;

  typedef enum logic [1:0] {
    SYNC = 2'd0,
    HIGH = 2'd1,
    LOW  = 2'd2
  } mon_state_t;

  localparam int EXP_HALF_DEF = 14;
  localparam int LOCK_N_DEF   = 4;
  localparam int ERR_CNT_W    = 8;

endpackage

// File: rtl/clk_div_monitor_phase_check.sv
// Combinational tolerance compare for one measured phase.
// Ports:
//   i_cnt  : measured phase length in clk_in cycles
//   o_pass : high when |i_cnt - EXP_HALF| <= TOL
module phase_check #(
  parameter int CNT_W    = 5,
  parameter int EXP_HALF = 14,
  parameter int TOL      = 0
) (
  input  logic [CNT_W-1:0] i_cnt,
  output logic             o_pass
);

  localparam logic signed [CNT_W:0] EXP_S = (CNT_W+1)'(EXP_HALF);

  logic signed [CNT_W:0] w_diff;
  logic signed [CNT_W:0] w_abs;

  // The extra bit keeps the difference representable when the count is
  // shorter than expected, so the magnitude can be taken safely.
  always_comb begin
    w_diff = $signed({1'b0, i_cnt}) - EXP_S;
    w_abs  = w_diff[CNT_W] ? -w_diff : w_diff;
    o_pass = (int'(w_abs) <= TOL);
  end

endmodule

// File: rtl/clk_div_monitor.sv
// Monitor for a divided clock generated in the clk_in domain.
// Measures every high and low phase of div_in in clk_in cycles, checks
// each against EXP_HALF +/- TOL, and reports lock and error status.
// Ports:
//   clk_in   : system clock, all logic on its rising edge
//   rst      : synchronous active-high reset
//   div_in   : divided clock under test (same clock domain)
//   locked   : high after LOCK_N consecutive good phase checks
//   err      : one-cycle pulse per failed check (mismatch or timeout)
//   high_len : last measured high-phase length
//   low_len  : last measured low-phase length
//   err_cnt  : failed-check count, saturating at 255
module clk_div_monitor
  import clk_mon_pkg::*;
#(
  parameter int EXP_HALF = EXP_HALF_DEF,
  parameter int TOL      = 0,
  parameter int LOCK_N   = LOCK_N_DEF,
  parameter int CNT_W    = $clog2(2*EXP_HALF+1)
) (
  input  logic                 clk_in,
  input  logic                 rst,
  input  logic                 div_in,
  output logic                 locked,
  output logic                 err,
  output logic [CNT_W-1:0]     high_len,
  output logic [CNT_W-1:0]     low_len,
  output logic [ERR_CNT_W-1:0] err_cnt
);

  localparam int GOOD_W = $clog2(LOCK_N+1);
  localparam logic [CNT_W-1:0]     CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0]     MAX_CNT   = CNT_W'(2*EXP_HALF);
  localparam logic [GOOD_W-1:0]    GOOD_ONE  = GOOD_W'(1);
  localparam logic [GOOD_W-1:0]    LOCK_V    = GOOD_W'(LOCK_N);
  localparam logic [GOOD_W-1:0]    LOCK_PRE  = GOOD_W'(LOCK_N-1);
  localparam logic [ERR_CNT_W-1:0] ERR_ONE   = ERR_CNT_W'(1);
  localparam logic [ERR_CNT_W-1:0] ERR_MAX   = '1;

  mon_state_t             r_state;
  logic                   r_divQ;
  logic                   r_primed;
  logic [CNT_W-1:0]       r_cnt;
  logic [GOOD_W-1:0]      r_goodCnt;
  logic                   r_locked;
  logic                   r_err;
  logic [CNT_W-1:0]       r_highLen;
  logic [CNT_W-1:0]       r_lowLen;
  logic [ERR_CNT_W-1:0]   r_errCnt;

  mon_state_t             w_nextState;
  logic [CNT_W-1:0]       w_nextCnt;
  logic                   w_rise;
  logic                   w_fall;
  logic                   w_pass;
  logic                   w_check;
  logic                   w_timeout;
  logic                   w_writeHigh;
  logic                   w_writeLow;

  // r_divQ is cleared by reset, so the first sample afterwards would look
  // like an edge whenever div_in happens to be high. r_primed masks edges
  // until r_divQ holds a real sample, which discards the interrupted phase.
  assign w_rise = r_primed &  div_in & ~r_divQ;
  assign w_fall = r_primed & ~div_in &  r_divQ;

  // One comparator serves both branches: whichever phase just ended is
  // the value sitting in r_cnt.
  phase_check #(
    .CNT_W    (CNT_W),
    .EXP_HALF (EXP_HALF),
    .TOL      (TOL)
  ) u_phaseCheck (
    .i_cnt  (r_cnt),
    .o_pass (w_pass)
  );

  // Next-state logic. An edge always wins over the timeout, and a timeout
  // abandons the measurement and waits for a fresh rising edge.
  always_comb begin
    w_nextState = r_state;
    w_nextCnt   = r_cnt;
    w_check     = 1'b0;
    w_timeout   = 1'b0;
    w_writeHigh = 1'b0;
    w_writeLow  = 1'b0;
    case (r_state)
      SYNC: begin
        w_nextCnt = '0;
        if (w_rise) begin
          w_nextState = HIGH;
          w_nextCnt   = CNT_ONE;
        end
      end
      HIGH: begin
        if (w_fall) begin
          w_check     = 1'b1;
          w_writeHigh = 1'b1;
          w_nextState = LOW;
          w_nextCnt   = CNT_ONE;
        end else if (r_cnt == MAX_CNT) begin
          w_timeout   = 1'b1;
          w_nextState = SYNC;
          w_nextCnt   = '0;
        end else begin
          w_nextCnt = r_cnt + CNT_ONE;
        end
      end
      LOW: begin
        if (w_rise) begin
          w_check     = 1'b1;
          w_writeLow  = 1'b1;
          w_nextState = HIGH;
          w_nextCnt   = CNT_ONE;
        end else if (r_cnt == MAX_CNT) begin
          w_timeout   = 1'b1;
          w_nextState = SYNC;
          w_nextCnt   = '0;
        end else begin
          w_nextCnt = r_cnt + CNT_ONE;
        end
      end
      default: begin
        w_nextState = SYNC;
        w_nextCnt   = '0;
      end
    endcase
  end

  // State, counters and registered status outputs. Lock is granted on the
  // check that brings the good count to LOCK_N; any failure drops it.
  always_ff @(posedge clk_in) begin
    if (rst) begin
      r_state   <= SYNC;
      r_divQ    <= 1'b0;
      r_primed  <= 1'b0;
      r_cnt     <= '0;
      r_goodCnt <= '0;
      r_locked  <= 1'b0;
      r_err     <= 1'b0;
      r_highLen <= '0;
      r_lowLen  <= '0;
      r_errCnt  <= '0;
    end else begin
      r_state  <= w_nextState;
      r_divQ   <= div_in;
      r_primed <= 1'b1;
      r_cnt    <= w_nextCnt;
      r_err    <= 1'b0;
      if (w_writeHigh) r_highLen <= r_cnt;
      if (w_writeLow)  r_lowLen  <= r_cnt;
      if (w_check && w_pass) begin
        if (r_goodCnt != LOCK_V) r_goodCnt <= r_goodCnt + GOOD_ONE;
        if (r_goodCnt >= LOCK_PRE) r_locked <= 1'b1;
      end else if (w_check || w_timeout) begin
        r_err     <= 1'b1;
        r_locked  <= 1'b0;
        r_goodCnt <= '0;
        if (r_errCnt != ERR_MAX) r_errCnt <= r_errCnt + ERR_ONE;
      end
    end
  end

  assign locked   = r_locked;
  assign err      = r_err;
  assign high_len = r_highLen;
  assign low_len  = r_lowLen;
  assign err_cnt  = r_errCnt;

endmodule

// File: tb/tb_clk_div_monitor.sv
// Directed self-checking bench for clk_div_monitor.
// Two instances watch the same div_in: one with TOL=0, one with TOL=1.
module tb_clk_div_monitor;

  logic       clkIn;
  logic       rst;
  logic       divIn;

  logic       locked,    lockedTol;
  logic       err,       errTol;
  logic [4:0] highLen,   highLenTol;
  logic [4:0] lowLen,    lowLenTol;
  logic [7:0] errCnt,    errCntTol;

  int checks;
  int failures;
  int errPulses;
  int errPulsesTol;
  int basePulses;

  logic       snapLocked, snapErr, snapLockedTol, snapErrTol;
  logic [4:0] snapHigh, snapLow, snapHighTol, snapLowTol;
  logic [7:0] snapErrCnt, snapErrCntTol;

  clk_div_monitor #(.EXP_HALF(14), .TOL(0), .LOCK_N(4)) dut (
    .clk_in   (clkIn),
    .rst      (rst),
    .div_in   (divIn),
    .locked   (locked),
    .err      (err),
    .high_len (highLen),
    .low_len  (lowLen),
    .err_cnt  (errCnt)
  );

  clk_div_monitor #(.EXP_HALF(14), .TOL(1), .LOCK_N(4)) dutTol (
    .clk_in   (clkIn),
    .rst      (rst),
    .div_in   (divIn),
    .locked   (lockedTol),
    .err      (errTol),
    .high_len (highLenTol),
    .low_len  (lowLenTol),
    .err_cnt  (errCntTol)
  );

  // Free-running 10 ns clock.
  initial clkIn = 1'b0;
  always #5 clkIn = ~clkIn;

  // Count err pulses half a cycle after each update.
  initial begin
    errPulses    = 0;
    errPulsesTol = 0;
  end
  always @(negedge clkIn) begin
    if (err === 1'b1)    errPulses++;
    if (errTol === 1'b1) errPulsesTol++;
  end

  task automatic tick();
    @(posedge clkIn);
    #1;
  endtask

  // Hold div_in at one level for n sampled edges; the outputs seen after
  // the first edge reflect the check of the phase that just ended.
  task automatic applyStimulus(input logic level, input int n);
    for (int i = 0; i < n; i++) begin
      divIn = level;
      tick();
      if (i == 0) begin
        snapLocked    = locked;
        snapErr       = err;
        snapHigh      = highLen;
        snapLow       = lowLen;
        snapErrCnt    = errCnt;
        snapLockedTol = lockedTol;
        snapErrTol    = errTol;
        snapHighTol   = highLenTol;
        snapLowTol    = lowLenTol;
        snapErrCntTol = errCntTol;
      end
    end
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst      = 1'b1;
    divIn    = 1'b0;

    // Reset for two cycles.
    tick();
    tick();
    checkOutput("reset_locked",  32'(locked),  0);
    checkOutput("reset_err",     32'(err),     0);
    checkOutput("reset_high",    32'(highLen), 0);
    checkOutput("reset_low",     32'(lowLen),  0);
    checkOutput("reset_errcnt",  32'(errCnt),  0);
    rst = 1'b0;
    applyStimulus(1'b0, 3);

    // Ideal 14/14 stimulus: lock after the fourth check.
    applyStimulus(1'b1, 14);
    applyStimulus(1'b0, 14);
    checkOutput("ideal_high1",   32'(snapHigh),   14);
    checkOutput("ideal_err1",    32'(snapErr),    0);
    applyStimulus(1'b1, 14);
    checkOutput("ideal_low1",    32'(snapLow),    14);
    applyStimulus(1'b0, 14);
    checkOutput("ideal_nolock3", 32'(snapLocked), 0);
    applyStimulus(1'b1, 14);
    checkOutput("ideal_lock4",   32'(snapLocked), 1);
    checkOutput("ideal_errcnt",  32'(snapErrCnt), 0);
    checkOutput("ideal_pulses",  32'(errPulses),  0);

    // One stretched high phase of 15.
    applyStimulus(1'b0, 14);
    applyStimulus(1'b1, 15);
    applyStimulus(1'b0, 14);
    checkOutput("stretch_err",    32'(snapErr),    1);
    checkOutput("stretch_high",   32'(snapHigh),   15);
    checkOutput("stretch_locked", 32'(snapLocked), 0);
    checkOutput("stretch_errcnt", 32'(snapErrCnt), 1);
    checkOutput("stretch_pulses", 32'(errPulses),  1);
    applyStimulus(1'b1, 14);
    applyStimulus(1'b0, 14);
    applyStimulus(1'b1, 14);
    checkOutput("relock_not3",    32'(snapLocked), 0);

    // Fourth good check relocks, then div_in stays low for 40 cycles.
    applyStimulus(1'b0, 40);
    checkOutput("relock_4",       32'(snapLocked), 1);
    checkOutput("timeout_errcnt", 32'(errCnt),     2);
    checkOutput("timeout_locked", 32'(locked),     0);
    checkOutput("timeout_pulses", 32'(errPulses),  2);
    checkOutput("timeout_low",    32'(lowLen),     14);
    checkOutput("timeout_high",   32'(highLen),    14);
    applyStimulus(1'b1, 14);
    checkOutput("resync_err",     32'(snapErr),    0);
    applyStimulus(1'b0, 14);
    applyStimulus(1'b1, 14);
    applyStimulus(1'b0, 14);
    checkOutput("resync_not3",    32'(snapLocked), 0);
    applyStimulus(1'b1, 14);
    checkOutput("resync_lock",    32'(snapLocked), 1);
    checkOutput("resync_errcnt",  32'(snapErrCnt), 2);
    checkOutput("resync_pulses",  32'(errPulses),  2);

    // Reset pulsed in the middle of a high phase while locked.
    applyStimulus(1'b0, 14);
    divIn = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checkOutput("midrst_locked", 32'(locked),  0);
    checkOutput("midrst_err",    32'(err),     0);
    checkOutput("midrst_high",   32'(highLen), 0);
    checkOutput("midrst_low",    32'(lowLen),  0);
    checkOutput("midrst_errcnt", 32'(errCnt),  0);
    for (int i = 0; i < 8; i++) tick();
    applyStimulus(1'b0, 14);
    checkOutput("midrst_fall_high", 32'(snapHigh), 0);
    checkOutput("midrst_fall_err",  32'(snapErr),  0);
    applyStimulus(1'b1, 14);
    checkOutput("midrst_rise_low",  32'(snapLow),  0);
    applyStimulus(1'b0, 14);
    checkOutput("midrst_first_high", 32'(snapHigh), 14);
    checkOutput("midrst_pulses",     32'(errPulses), 2);

    // 300 phases of 13 cycles: every one fails, counter saturates.
    basePulses = errPulses;
    for (int i = 0; i < 300; i++) applyStimulus((i % 2 == 0) ? 1'b1 : 1'b0, 13);
    applyStimulus(1'b1, 14);
    checkOutput("sat_errcnt", 32'(snapErrCnt), 255);
    checkOutput("sat_pulses", 32'(errPulses - basePulses), 300);
    checkOutput("sat_locked", 32'(snapLocked), 0);

    // Tolerance of one: 13/15 alternation locks, a 16 phase fails.
    rst   = 1'b1;
    divIn = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    applyStimulus(1'b0, 3);
    basePulses = errPulsesTol;
    applyStimulus(1'b1, 13);
    applyStimulus(1'b0, 15);
    checkOutput("tol_high13", 32'(snapHighTol), 13);
    checkOutput("tol_err13",  32'(snapErrTol),  0);
    applyStimulus(1'b1, 13);
    checkOutput("tol_low15",  32'(snapLowTol),  15);
    applyStimulus(1'b0, 15);
    checkOutput("tol_not3",   32'(snapLockedTol), 0);
    applyStimulus(1'b1, 13);
    checkOutput("tol_lock",   32'(snapLockedTol), 1);
    checkOutput("tol_errcnt0", 32'(snapErrCntTol), 0);
    applyStimulus(1'b0, 16);
    checkOutput("tol_stay",   32'(snapLockedTol), 1);
    applyStimulus(1'b1, 14);
    checkOutput("tol16_err",    32'(snapErrTol),    1);
    checkOutput("tol16_low",    32'(snapLowTol),    16);
    checkOutput("tol16_locked", 32'(snapLockedTol), 0);
    checkOutput("tol16_errcnt", 32'(snapErrCntTol), 1);
    checkOutput("tol_pulses",   32'(errPulsesTol - basePulses), 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
